video_timing_gen: RTL and testbench



---
 rtl/video_timing_gen_if.sv | 16 +
 rtl/video_timing_gen.sv | 57 +++++
 tb/tb_video_timing_gen.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/video_timing_gen_if.sv
// video_timing_gen_if: raster timing bundle from the timing generator to pixel pipeline and serializer
// master: drives counters, coordinates, strobes and delayed sync/blank; slave: observes them
interface video_timing_gen_if;
  logic [11:0] h_count;
  logic [11:0] v_count;
  logic [11:0] x;
  logic [11:0] y;
  logic        active;
  logic        line_start;
  logic        frame_start;
  logic        hs;
  logic        vs;
  logic        blk;
  modport master (output h_count, v_count, x, y, active, line_start, frame_start, hs, vs, blk);
  modport slave  (input  h_count, v_count, x, y, active, line_start, frame_start, hs, vs, blk);
endinterface

// File: rtl/video_timing_gen.sv
// video_timing_gen: free-running raster counters with stage-0 decode and a delayed sync/blank chain
// Ports: clk (pixel clock), reset (async, active-high), vt (master side of video_timing_gen_if:
// h_count/v_count, x/y, active, line_start, frame_start, delayed hs/vs/blk)
module video_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_POL   = 0,
  parameter int PIPE_DELAY = 2
) (
  input logic clk,
  input logic reset,
  video_timing_gen_if.master vt
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  logic [11:0] h, v;
  logic        h_last, v_last, act, hs0, vs0;
  // each stage holds {hs, vs, blk}; reset value is the idle/blanking pattern
  logic [2:0]  chain [PIPE_DELAY];
  assign h_last = int'(h) == H_TOTAL - 1;
  assign v_last = int'(v) == V_TOTAL - 1;
  assign act    = (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE);
  assign hs0    = (int'(h) >= H_ACTIVE + H_FP) && (int'(h) < H_ACTIVE + H_FP + H_SYNC);
  assign vs0    = (int'(v) >= V_ACTIVE + V_FP) && (int'(v) < V_ACTIVE + V_FP + V_SYNC);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      h <= '0;
      v <= '0;
    end else begin
      h <= h_last ? '0 : h + 12'd1;
      if (h_last) v <= v_last ? '0 : v + 12'd1;
    end
  // reset flushes the whole chain so sync/blank go idle without waiting for clocks
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < PIPE_DELAY; i++) chain[i] <= 3'b001;
    end else begin
      chain[0] <= {hs0, vs0, !act};
      for (int i = 1; i < PIPE_DELAY; i++) chain[i] <= chain[i-1];
    end
  assign vt.h_count     = h;
  assign vt.v_count     = v;
  assign vt.x           = h;
  assign vt.y           = v;
  assign vt.active      = act;
  assign vt.line_start  = h == '0;
  assign vt.frame_start = (h == '0) && (v == '0);
  assign vt.hs          = (SYNC_POL != 0) ? chain[PIPE_DELAY-1][2] : !chain[PIPE_DELAY-1][2];
  assign vt.vs          = (SYNC_POL != 0) ? chain[PIPE_DELAY-1][1] : !chain[PIPE_DELAY-1][1];
  assign vt.blk         = chain[PIPE_DELAY-1][0];
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: checks four generator configurations against an arithmetic raster model
module tb_video_timing_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   t = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   act_cnt = 0;
  int   last_fs2 = -1;
  int   last_ls0 = -1;

  typedef struct packed {
    int   h;
    int   v;
    logic act, ls, fs, hs, vs, blk;
  } exp_t;

  video_timing_gen_if i0 ();
  video_timing_gen_if i1 ();
  video_timing_gen_if i2 ();
  video_timing_gen_if i3 ();

  video_timing_gen d0 (.clk(clk), .reset(reset), .vt(i0));
  video_timing_gen #(.V_ACTIVE(24), .V_FP(3), .V_SYNC(2), .V_BP(4)) d1 (.clk(clk), .reset(reset), .vt(i1));
  video_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1))
    d2 (.clk(clk), .reset(reset), .vt(i2));
  video_timing_gen #(.SYNC_POL(1), .PIPE_DELAY(1)) d3 (.clk(clk), .reset(reset), .vt(i3));

  always #5 clk = ~clk;

  // edges since reset was released; the raster position is pure arithmetic on this
  always @(posedge clk or posedge reset)
    if (reset) t <= 0;
    else t <= t + 1;

  function automatic exp_t model(int tt, int ha, int hf, int hw, int hb, int va, int vf, int vw, int vb, int pol, int pd);
    exp_t e;
    int ht = ha + hf + hw + hb;
    int vt = va + vf + vw + vb;
    int th, tv;
    logic hs0, vs0, blk0;
    e.h   = tt % ht;
    e.v   = (tt / ht) % vt;
    e.act = (e.h < ha) && (e.v < va);
    e.ls  = e.h == 0;
    e.fs  = e.h == 0 && e.v == 0;
    if (tt >= pd) begin
      th   = (tt - pd) % ht;
      tv   = ((tt - pd) / ht) % vt;
      hs0  = th >= ha + hf && th < ha + hf + hw;
      vs0  = tv >= va + vf && tv < va + vf + vw;
      blk0 = !(th < ha && tv < va);
    end else begin
      hs0  = 1'b0;
      vs0  = 1'b0;
      blk0 = 1'b1;
    end
    e.hs  = pol != 0 ? hs0 : !hs0;
    e.vs  = pol != 0 ? vs0 : !vs0;
    e.blk = blk0;
    return e;
  endfunction

  task automatic check(string nm, int got, int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s t=%0d got %0d expected %0d", nm, t, got, want);
  endtask

  task automatic cmp(string n, exp_t e, logic [11:0] h, logic [11:0] v, logic [11:0] x, logic [11:0] y,
                     logic a, logic ls, logic fs, logic hs, logic vs, logic blk);
    check({n, ".h_count"}, int'(h), e.h);
    check({n, ".v_count"}, int'(v), e.v);
    check({n, ".active"}, int'(a), int'(e.act));
    check({n, ".line_start"}, int'(ls), int'(e.ls));
    check({n, ".frame_start"}, int'(fs), int'(e.fs));
    check({n, ".hs"}, int'(hs), int'(e.hs));
    check({n, ".vs"}, int'(vs), int'(e.vs));
    check({n, ".blk"}, int'(blk), int'(e.blk));
    if (e.act) begin
      check({n, ".x"}, int'(x), e.h);
      check({n, ".y"}, int'(y), e.v);
    end
  endtask

  always @(negedge clk) begin
    cmp("d0", model(t, 640, 16, 96, 48, 480, 10, 2, 33, 0, 2), i0.h_count, i0.v_count, i0.x, i0.y,
        i0.active, i0.line_start, i0.frame_start, i0.hs, i0.vs, i0.blk);
    cmp("d1", model(t, 640, 16, 96, 48, 24, 3, 2, 4, 0, 2), i1.h_count, i1.v_count, i1.x, i1.y,
        i1.active, i1.line_start, i1.frame_start, i1.hs, i1.vs, i1.blk);
    cmp("d2", model(t, 4, 1, 2, 1, 3, 1, 1, 1, 0, 2), i2.h_count, i2.v_count, i2.x, i2.y,
        i2.active, i2.line_start, i2.frame_start, i2.hs, i2.vs, i2.blk);
    cmp("d3", model(t, 640, 16, 96, 48, 480, 10, 2, 33, 1, 1), i3.h_count, i3.v_count, i3.x, i3.y,
        i3.active, i3.line_start, i3.frame_start, i3.hs, i3.vs, i3.blk);
    if (reset) begin
      act_cnt  = 0;
      last_fs2 = -1;
      last_ls0 = -1;
    end else begin
      if (t < 26400 && i1.active) act_cnt++;
      if (t == 26400) check("d1_active_cycles_frame0", act_cnt, 15360);
      if (i2.frame_start) begin
        if (last_fs2 >= 0) check("d2_frame_start_gap", t - last_fs2, 48);
        last_fs2 = t;
      end
      if (i0.line_start) begin
        if (last_ls0 >= 0) check("d0_line_start_gap", t - last_ls0, 800);
        last_ls0 = t;
      end
      case (t)
        0: begin
          check("lit_d0_h0", int'(i0.h_count), 0);
          check("lit_d0_v0", int'(i0.v_count), 0);
          check("lit_d0_active0", int'(i0.active), 1);
          check("lit_d0_fs0", int'(i0.frame_start), 1);
          check("lit_d0_hs0", int'(i0.hs), 1);
          check("lit_d0_vs0", int'(i0.vs), 1);
          check("lit_d0_blk0", int'(i0.blk), 1);
          check("lit_d3_hs0", int'(i3.hs), 0);
          check("lit_d3_vs0", int'(i3.vs), 0);
        end
        1: begin
          check("lit_d0_h1", int'(i0.h_count), 1);
          check("lit_d0_fs1", int'(i0.frame_start), 0);
        end
        7: begin
          check("lit_d2_h7", int'(i2.h_count), 7);
          check("lit_d2_v7", int'(i2.v_count), 0);
        end
        8: begin
          check("lit_d2_h8", int'(i2.h_count), 0);
          check("lit_d2_v8", int'(i2.v_count), 1);
        end
        47: begin
          check("lit_d2_h47", int'(i2.h_count), 7);
          check("lit_d2_v47", int'(i2.v_count), 5);
        end
        48: begin
          check("lit_d2_h48", int'(i2.h_count), 0);
          check("lit_d2_v48", int'(i2.v_count), 0);
          check("lit_d2_fs48", int'(i2.frame_start), 1);
        end
        639: check("lit_d0_active639", int'(i0.active), 1);
        640: check("lit_d0_active640", int'(i0.active), 0);
        641: check("lit_d0_blk641", int'(i0.blk), 0);
        642: check("lit_d0_blk642", int'(i0.blk), 1);
        656: check("lit_d3_hs656", int'(i3.hs), 0);
        657: begin
          check("lit_d0_hs657", int'(i0.hs), 1);
          check("lit_d3_hs657", int'(i3.hs), 1);
        end
        658: check("lit_d0_hs658", int'(i0.hs), 0);
        752: check("lit_d3_hs752", int'(i3.hs), 1);
        753: begin
          check("lit_d0_hs753", int'(i0.hs), 0);
          check("lit_d3_hs753", int'(i3.hs), 0);
        end
        754: check("lit_d0_hs754", int'(i0.hs), 1);
        801: check("lit_d0_blk801", int'(i0.blk), 1);
        802: check("lit_d0_blk802", int'(i0.blk), 0);
        21601: check("lit_d1_vs21601", int'(i1.vs), 1);
        21602: check("lit_d1_vs21602", int'(i1.vs), 0);
        23201: check("lit_d1_vs23201", int'(i1.vs), 0);
        23202: check("lit_d1_vs23202", int'(i1.vs), 1);
        default: ;
      endcase
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    repeat (42700) @(posedge clk);
    #1;
    check("mid_d1_h_before", int'(i1.h_count), 300);
    check("mid_d1_v_before", int'(i1.v_count), 20);
    #2 reset = 1'b1;
    #1;
    check("mid_d1_h_reset", int'(i1.h_count), 0);
    check("mid_d1_v_reset", int'(i1.v_count), 0);
    check("mid_d1_hs_reset", int'(i1.hs), 1);
    check("mid_d1_vs_reset", int'(i1.vs), 1);
    check("mid_d1_blk_reset", int'(i1.blk), 1);
    check("mid_d3_hs_reset", int'(i3.hs), 0);
    check("mid_d3_vs_reset", int'(i3.vs), 0);
    check("mid_d3_blk_reset", int'(i3.blk), 1);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    repeat (2000) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
